// File: rtl/axis_sample_tx_pkg.sv
// Shared sample type and defaults for the FIR input streaming path.
package axis_tx_pkg;
    localparam int SAMPLE_W = 16;
    localparam int FIR_TAPS = 19;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/axis_sample_tx_if.sv
// AXI4-Stream data bus toward the FIR s_axis_data port.
// Optional tlast wire is present only when AXIS_TX_TLAST_EN is defined.
interface axis_sample_tx_if #(
    parameter int DATA_W = 16
);
    logic              m_axis_data_tvalid;
    logic              m_axis_data_tready;
    logic [DATA_W-1:0] m_axis_data_tdata;
`ifdef AXIS_TX_TLAST_EN
    logic              m_axis_data_tlast;

    modport master (
        output m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast,
        input  m_axis_data_tready
    );
    modport slave (
        input  m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast,
        output m_axis_data_tready
    );
`else
    modport master (
        output m_axis_data_tvalid, m_axis_data_tdata,
        input  m_axis_data_tready
    );
    modport slave (
        input  m_axis_data_tvalid, m_axis_data_tdata,
        output m_axis_data_tready
    );
`endif
endinterface

// File: rtl/axis_sample_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push/pop are ignored when full/empty.
module axis_tx_fifo
    import axis_tx_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_push;
    logic              w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && w_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign dout  = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;
endmodule

// File: rtl/axis_sample_tx.sv
// Sample FIFO plus registered AXI4-Stream master stage feeding the FIR filter.
// Define AXIS_TX_TLAST_EN to add the frame counter and tlast output.
module axis_sample_tx
    import axis_tx_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = FIR_TAPS
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wr_en,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level,
    axis_sample_tx_if.master        m_axis
);
    logic              w_full;
    logic              w_empty;
    logic              w_load;
    logic [DATA_W-1:0] w_dout;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_overflow;

    axis_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (wr_en),
        .pop     (w_load),
        .din     (wr_data),
        .dout    (w_dout),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // Refill the output register whenever it is free or being drained this cycle.
    assign w_load = !w_empty && (!r_tvalid || m_axis.m_axis_data_tready);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_tvalid   <= 1'b0;
            r_tdata    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_dout;
            end else if (r_tvalid && m_axis.m_axis_data_tready) begin
                r_tvalid <= 1'b0;
            end
            if (wr_en && w_full) r_overflow <= 1'b1;
        end
    end

    assign wr_ready                  = !w_full;
    assign overflow                  = r_overflow;
    assign m_axis.m_axis_data_tvalid = r_tvalid;
    assign m_axis.m_axis_data_tdata  = r_tdata;

`ifdef AXIS_TX_TLAST_EN
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CW-1:0] r_beat_cnt;
    logic          r_tlast;
    logic          w_frame_end;

    assign w_frame_end = (r_beat_cnt == CW'(FRAME_LEN - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_beat_cnt <= '0;
            r_tlast    <= 1'b0;
        end else if (w_load) begin
            r_tlast    <= w_frame_end;
            r_beat_cnt <= w_frame_end ? '0 : r_beat_cnt + 1'b1;
        end
    end

    assign m_axis.m_axis_data_tlast = r_tlast;
`endif
endmodule

// File: tb/tb_axis_sample_tx.sv
// Scoreboard bench for axis_sample_tx: directed writes push expectations, a monitor checks beats.
module tb_axis_sample_tx;
    import axis_tx_pkg::*;

    localparam int DATA_W    = 16;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = FIR_TAPS;
    localparam int LW        = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              overflow;
    logic [LW-1:0]     level;

    axis_sample_tx_if #(.DATA_W(DATA_W)) m_axis ();

    axis_sample_tx #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .overflow (overflow),
        .level    (level),
        .m_axis   (m_axis)
    );

    always #5 aclk = ~aclk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   beat_cnt = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Every accepted write becomes the next output load, so the frame position follows writes.
    task automatic push_exp(input logic [DATA_W-1:0] d);
        exp_t e;
        e.data = d;
        e.last = (beat_cnt == FRAME_LEN - 1);
        beat_cnt = e.last ? 0 : beat_cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [DATA_W-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) push_exp(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        exp_q.delete();
        beat_cnt = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_axis.m_axis_data_tready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        tick();
        chk({name, "_idle_tvalid"}, m_axis.m_axis_data_tvalid, 0);
    endtask

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && m_axis.m_axis_data_tvalid === 1'b1 && m_axis.m_axis_data_tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected actual=%h expected=none", m_axis.m_axis_data_tdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_axis.m_axis_data_tdata !== e.data) begin
                    errors++;
                    $display("FAIL beat_data actual=%h expected=%h", m_axis.m_axis_data_tdata, e.data);
                end
`ifdef AXIS_TX_TLAST_EN
                if (m_axis.m_axis_data_tlast !== e.last) begin
                    errors++;
                    $display("FAIL beat_tlast data=%h actual=%b expected=%b",
                             e.data, m_axis.m_axis_data_tlast, e.last);
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        m_axis.m_axis_data_tready = 1'b0;

        // Reset held 3 cycles with wr_en high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_tvalid", m_axis.m_axis_data_tvalid, 0);
            chk("rst_level", level, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_wr_ready", wr_ready, 1);
        end
        chk("rst_tdata", m_axis.m_axis_data_tdata, 0);
        wr_en   = 1'b0;
        aresetn = 1'b1;
        tick();
        chk("post_rst_tvalid", m_axis.m_axis_data_tvalid, 0);

        // Streaming 1..5 back to back with tready high.
        m_axis.m_axis_data_tready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_en   = 1'b1;
            wr_data = DATA_W'(i);
            push_exp(DATA_W'(i));
            tick();
            chk($sformatf("stream_tvalid_%0d", i), m_axis.m_axis_data_tvalid, (i >= 2) ? 1 : 0);
        end
        wr_en = 1'b0;
        tick();
        chk("stream_tvalid_last", m_axis.m_axis_data_tvalid, 1);
        tick();
        chk("stream_tvalid_done", m_axis.m_axis_data_tvalid, 0);
        chk("stream_left", exp_q.size(), 0);

        // Backpressure with extreme values.
        m_axis.m_axis_data_tready = 1'b0;
        wr(16'h7FFF, 1);
        wr(16'h8000, 1);
        chk("bp_tvalid", m_axis.m_axis_data_tvalid, 1);
        chk("bp_tdata", m_axis.m_axis_data_tdata, 32'h7FFF);
        chk("bp_level", level, 1);
        tick();
        chk("bp_hold_tdata", m_axis.m_axis_data_tdata, 32'h7FFF);
        chk("bp_hold_tvalid", m_axis.m_axis_data_tvalid, 1);
        drain("bp");

        // Full and overflow: 16 in the FIFO plus one held, the 18th dropped.
        m_axis.m_axis_data_tready = 1'b0;
        chk("pre_full_overflow", overflow, 0);
        for (int i = 0; i < 18; i++) wr(16'hA000 + 16'(i), i < 17);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_overflow", overflow, 1);
        chk("full_level", level, DEPTH);
        chk("full_tdata", m_axis.m_axis_data_tdata, 32'hA000);
        drain("full");
        chk("full_level_after", level, 0);
        chk("full_overflow_sticky", overflow, 1);
        chk("full_wr_ready_after", wr_ready, 1);

        // Reset mid-operation with 8 queued and one held.
        m_axis.m_axis_data_tready = 1'b0;
        for (int i = 0; i < 9; i++) wr(16'hB000 + 16'(i), 1);
        chk("mid_level", level, 8);
        do_reset();
        chk("mid_rst_tvalid", m_axis.m_axis_data_tvalid, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_overflow", overflow, 0);
        wr(16'h0042, 1);
        drain("mid");

        // Random tready stream; frame boundaries at beats 19 and 38 when tlast is enabled.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            int n = 0;
            while (wr_ready !== 1'b1 && n < 100) begin
                m_axis.m_axis_data_tready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            if (n >= 100) chk("rand_wr_ready_timeout", 0, 1);
            m_axis.m_axis_data_tready = 1'($urandom_range(0, 1));
            wr(16'hC000 + 16'(i), 1);
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
